// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron branch predictor: branch-kind encodings,
// saturating weight arithmetic and the default training threshold.
package perceptron_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_JUMP = 2'd2;
  localparam logic [1:0] BR_COND = 2'd3;

  // floor(1.93*history + 14), kept in integer arithmetic
  function automatic int default_threshold(input int history);
    return (193 * history) / 100 + 14;
  endfunction

  function automatic int sat_inc(input int w, input int width);
    int max_w;
    max_w = (1 << (width - 1)) - 1;
    return (w >= max_w) ? max_w : w + 1;
  endfunction

  function automatic int sat_dec(input int w, input int width);
    int min_w;
    min_w = -(1 << (width - 1));
    return (w <= min_w) ? min_w : w - 1;
  endfunction

endpackage

// File: rtl/perceptron_train.sv
// Combinational training step for one perceptron: decides whether to train and
// produces the saturated next weight vector (index 0 = bias, i+1 = history bit i).
module perceptron_train
  import perceptron_pkg::*;
#(
  parameter int HISTORY      = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_W        = 12,
  parameter int THRESHOLD    = 29
) (
  input  logic [HISTORY:0][WEIGHT_WIDTH-1:0] weights,
  input  logic [HISTORY-1:0]                 history,
  input  logic                               taken,
  input  logic signed [SUM_W-1:0]            sum,
  output logic [HISTORY:0][WEIGHT_WIDTH-1:0] next_weights,
  output logic                               train_en
);

  function automatic logic [WEIGHT_WIDTH-1:0] step(input logic [WEIGHT_WIDTH-1:0] w,
                                                   input logic up);
    int wi;
    wi = int'($signed(w));
    return up ? WEIGHT_WIDTH'(sat_inc(wi, WEIGHT_WIDTH))
              : WEIGHT_WIDTH'(sat_dec(wi, WEIGHT_WIDTH));
  endfunction

  int   sum_i;
  int   sum_abs;
  logic mispredict;

  always_comb begin
    sum_i        = int'(sum);
    sum_abs      = (sum_i < 0) ? -sum_i : sum_i;
    mispredict   = (sum_i >= 0) != taken;
    train_en     = mispredict || (sum_abs <= THRESHOLD);
    next_weights = weights;
    next_weights[0] = step(weights[0], taken);
    for (int i = 0; i < HISTORY; i++) begin
      next_weights[i+1] = step(weights[i+1], history[i] == taken);
    end
  end

endmodule

// File: rtl/perceptron_predictor_table.sv
// PC-indexed perceptron branch predictor with a speculative global history
// register, one-cycle registered prediction and training on branch resolve.
module perceptron_predictor_table
  import perceptron_pkg::*;
#(
  parameter int HISTORY      = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int INDEX_BITS   = 4,
  parameter int PC_WIDTH     = 32,
  parameter int THRESHOLD    = default_threshold(HISTORY),
  parameter int SUM_W        = WEIGHT_WIDTH + $clog2(HISTORY + 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_req,
  input  logic [PC_WIDTH-1:0]        pred_pc,
  input  logic [1:0]                 branch_inst,
  output logic                       pred_valid,
  output logic                       prediction,
  output logic signed [SUM_W-1:0]    pred_sum,
  output logic [HISTORY-1:0]         pred_history,
  input  logic                       upd_valid,
  input  logic [PC_WIDTH-1:0]        upd_pc,
  input  logic                       upd_taken,
  input  logic signed [SUM_W-1:0]    upd_sum,
  input  logic [HISTORY-1:0]         upd_history,
  output logic [HISTORY-1:0]         ghr
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [HISTORY:0][WEIGHT_WIDTH-1:0] table_q [ENTRIES];

  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  unused_pc;

  assign pred_idx  = pred_pc[INDEX_BITS+1:2];
  assign upd_idx   = upd_pc[INDEX_BITS+1:2];
  assign unused_pc = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0],
                       upd_pc[PC_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

  // Dot product reads the table before this edge's training write lands.
  logic signed [SUM_W-1:0]        dot_sum;
  logic signed [WEIGHT_WIDTH-1:0] w_s;

  always_comb begin
    dot_sum = SUM_W'($signed(table_q[pred_idx][0]));
    w_s     = '0;
    for (int i = 0; i < HISTORY; i++) begin
      w_s = $signed(table_q[pred_idx][i+1]);
      if (ghr[i]) dot_sum = dot_sum + SUM_W'(w_s);
      else        dot_sum = dot_sum - SUM_W'(w_s);
    end
  end

  logic                    nxt_pred;
  logic signed [SUM_W-1:0] nxt_sum;
  logic                    is_cond;

  always_comb begin
    nxt_pred = 1'b0;
    nxt_sum  = '0;
    is_cond  = 1'b0;
    case (branch_inst)
      BR_JUMP: nxt_pred = 1'b1;
      BR_COND: begin
        nxt_pred = ~dot_sum[SUM_W-1];
        nxt_sum  = dot_sum;
        is_cond  = 1'b1;
      end
      BR_NONE: nxt_pred = 1'b0;
      default: nxt_pred = 1'b0;
    endcase
  end

  logic [HISTORY:0][WEIGHT_WIDTH-1:0] trained_w;
  logic                               train_en;
  logic                               upd_mispredict;

  assign upd_mispredict = upd_valid && ((~upd_sum[SUM_W-1]) != upd_taken);

  perceptron_train #(
    .HISTORY      (HISTORY),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .SUM_W        (SUM_W),
    .THRESHOLD    (THRESHOLD)
  ) u_train (
    .weights      (table_q[upd_idx]),
    .history      (upd_history),
    .taken        (upd_taken),
    .sum          (upd_sum),
    .next_weights (trained_w),
    .train_en     (train_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) table_q[e] <= '0;
    end else if (upd_valid && train_en) begin
      table_q[upd_idx] <= trained_w;
    end
  end

  // Mispredict repair takes priority over the speculative shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr          <= '0;
      pred_valid   <= 1'b0;
      prediction   <= 1'b0;
      pred_sum     <= '0;
      pred_history <= '0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) begin
        prediction   <= nxt_pred;
        pred_sum     <= nxt_sum;
        pred_history <= ghr;
      end
      if (upd_mispredict) begin
        ghr <= {upd_history[HISTORY-2:0], upd_taken};
      end else if (pred_req && is_cond) begin
        ghr <= {ghr[HISTORY-2:0], nxt_pred};
      end
    end
  end

endmodule

// File: tb/tb_perceptron_predictor_table.sv
// Directed bench for perceptron_predictor_table: hand-computed predictions,
// training, saturation, threshold, GHR repair and asynchronous reset.
module tb_perceptron_predictor_table;

  localparam int HISTORY = 8;
  localparam int SUM_W   = 12;

  logic                     clk;
  logic                     rst;
  logic                     pred_req;
  logic [31:0]              pred_pc;
  logic [1:0]               branch_inst;
  logic                     pred_valid;
  logic                     prediction;
  logic signed [SUM_W-1:0]  pred_sum;
  logic [HISTORY-1:0]       pred_history;
  logic                     upd_valid;
  logic [31:0]              upd_pc;
  logic                     upd_taken;
  logic signed [SUM_W-1:0]  upd_sum;
  logic [HISTORY-1:0]       upd_history;
  logic [HISTORY-1:0]       ghr;

  int total;
  int bad;

  perceptron_predictor_table dut (
    .clk          (clk),
    .rst          (rst),
    .pred_req     (pred_req),
    .pred_pc      (pred_pc),
    .branch_inst  (branch_inst),
    .pred_valid   (pred_valid),
    .prediction   (prediction),
    .pred_sum     (pred_sum),
    .pred_history (pred_history),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_sum      (upd_sum),
    .upd_history  (upd_history),
    .ghr          (ghr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_pred(input logic [31:0] pc, input logic [1:0] br);
    pred_req    = 1'b1;
    pred_pc     = pc;
    branch_inst = br;
    tick();
    pred_req    = 1'b0;
    branch_inst = 2'd0;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken,
                        input logic [7:0] hist, input int sum);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = taken;
    upd_history = hist;
    upd_sum     = SUM_W'(sum);
    tick();
    upd_valid   = 1'b0;
  endtask

  task automatic check_pred(input string tag, input int v, input int p, input int s,
                            input int h, input int g);
    check({tag, ".valid"}, int'(pred_valid), v);
    check({tag, ".pred"},  int'(prediction), p);
    check({tag, ".sum"},   int'(pred_sum), s);
    check({tag, ".hist"},  int'(pred_history), h);
    check({tag, ".ghr"},   int'(ghr), g);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    pred_req = 1'b0; pred_pc = '0; branch_inst = 2'd0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_sum = '0; upd_history = '0;
    tick();
    tick();
    check_pred("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // zero weights, ghr=0: sum 0 -> taken, ghr shifts in 1
    do_pred(32'h40, 2'd3);
    check_pred("first", 1, 1, 0, 0, 8'h01);
    tick();
    check("pulse.valid", int'(pred_valid), 0);
    check("hold.pred", int'(prediction), 1);

    // mispredict: bias -1, all w +1, ghr repaired to 0
    do_upd(32'h40, 1'b0, 8'h00, 0);
    check("upd1.ghr", int'(ghr), 0);
    do_pred(32'h40, 2'd3);
    check_pred("after_upd1", 1, 0, -9, 0, 0);

    // 200 consecutive trainings to entry 0 saturate everything at +127
    for (int k = 0; k < 200; k++) do_upd(32'h40, 1'b1, 8'hFF, 0);
    check("sat.ghr", int'(ghr), 0);
    do_pred(32'h40, 2'd3);
    check_pred("sat_ghr0", 1, 0, 127 - 8 * 127, 0, 0);
    do_upd(32'h44, 1'b1, 8'h7F, -1);
    check("repair_ff.ghr", int'(ghr), 8'hFF);
    do_pred(32'h40, 2'd3);
    check_pred("sat_ghrff", 1, 1, 9 * 127, 8'hFF, 8'hFF);

    // threshold: correct with |sum|=40 leaves entry 2 untouched
    do_upd(32'h48, 1'b1, 8'h00, 40);
    check("thr40.ghr", int'(ghr), 8'hFF);
    do_pred(32'h48, 2'd3);
    check_pred("thr40", 1, 1, 0, 8'hFF, 8'hFF);
    // |sum|=29 trains: bias +1, all w -1
    do_upd(32'h48, 1'b1, 8'h00, 29);
    do_pred(32'h48, 2'd3);
    check_pred("thr29", 1, 0, 1 - 8, 8'hFF, 8'hFE);

    // set ghr to A5 via repair on entry 3
    do_upd(32'h4C, 1'b1, 8'h52, -1);
    check("set_a5.ghr", int'(ghr), 8'hA5);

    // simultaneous repair + predict on the entry being trained
    upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1;
    upd_history = 8'h3C; upd_sum = SUM_W'(-5);
    do_pred(32'h48, 2'd3);
    upd_valid = 1'b0;
    check_pred("repair", 1, 1, 1, 8'hA5, 8'h79);
    // entry 2 now: bias 2, w2..w5 = 0, others -2
    do_pred(32'h48, 2'd3);
    check_pred("post_repair", 1, 1, 2, 8'h79, 8'hF3);

    do_pred(32'h48, 2'd2);
    check_pred("jump", 1, 1, 0, 8'hF3, 8'hF3);
    do_pred(32'h48, 2'd0);
    check_pred("none", 1, 0, 0, 8'hF3, 8'hF3);
    do_pred(32'h48, 2'd1);
    check_pred("br1", 1, 0, 0, 8'hF3, 8'hF3);
    tick();
    check("idle.valid", int'(pred_valid), 0);
    check("idle.hist", int'(pred_history), 8'hF3);

    // saturated entry with ghr F3 (6 ones): 127 + 127*4
    do_pred(32'h40, 2'd3);
    check_pred("pre_rst", 1, 1, 635, 8'hF3, 8'hE7);
    #3;
    rst = 1'b1;
    #1;
    check_pred("async_rst", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    do_pred(32'h40, 2'd3);
    check_pred("after_rst", 1, 1, 0, 0, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
